// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
package aes_sched_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_KEY_W   = 128;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KEY_LOAD = 3'd1,
        ST_KEY_WAIT = 3'd2,
        ST_START    = 3'd3,
        ST_RUN      = 3'd4,
        ST_RESP     = 3'd5
    } aes_sched_state_t;

    typedef logic [0:0] req_idx_t;

    // One-hot requester vector for a requester index.
    function automatic logic [1:0] onehot_idx(input req_idx_t idx);
        return (idx == 1'b1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin arbiter. The priority pointer names the requester that
// wins a tie; on update it moves to the requester that was not just served.
module aes_rr_arbiter
    import aes_sched_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt_valid,
    output req_idx_t   gnt_idx
);

    req_idx_t prio_r;

    // Grant the priority requester if it asks, otherwise the other one.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = prio_r;
        if (req[prio_r]) begin
            gnt_idx = prio_r;
        end else begin
            gnt_idx = ~prio_r;
        end
    end

    // Hand priority to the other requester after every accepted job.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_r <= 1'b0;
        end else if (update) begin
            prio_r <= ~gnt_idx;
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES-128 core between the AXI front-end (requester 0) and the
// trace-campaign plaintext generator (requester 1). Skips key expansion when
// the loaded key is reused and frames the encryption window on trig_o.
// Optional watchdog: define AES_SCHED_WATCHDOG_EN.
module aes_job_scheduler
    import aes_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0][AES_KEY_W-1:0]   req_key,
    input  logic [1:0][AES_BLOCK_W-1:0] req_data,
    output logic [1:0]                  rsp_valid,
    input  logic [1:0]                  rsp_ready,
    output logic [AES_BLOCK_W-1:0]      rsp_data,
    output logic                        rsp_err,
    output logic [AES_KEY_W-1:0]        core_key,
    output logic [AES_BLOCK_W-1:0]      core_data,
    output logic                        core_key_load,
    input  logic                        core_key_done,
    output logic                        core_start,
    input  logic                        core_done,
    input  logic [AES_BLOCK_W-1:0]      core_result,
    output logic                        trig_o,
    output logic                        busy_o
);

    aes_sched_state_t       state_r;
    req_idx_t               owner_r;
    logic                   key_valid_r;
    logic [AES_KEY_W-1:0]   loaded_key_r;
    logic [AES_KEY_W-1:0]   core_key_r;
    logic [AES_BLOCK_W-1:0] core_data_r;
    logic                   core_key_load_r;
    logic                   core_start_r;
    logic                   trig_r;
    logic                   busy_r;
    logic [1:0]             rsp_valid_r;
    logic [AES_BLOCK_W-1:0] rsp_data_r;
    logic                   rsp_err_r;

    logic       gnt_valid_s;
    req_idx_t   gnt_idx_s;
    logic [1:0] req_ready_s;
    logic       accept_s;
    logic       key_miss_s;
    logic       wd_expire_s;

    aes_rr_arbiter u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid),
        .update    (accept_s),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Offer the slot to the granted requester only while idle and out of reset.
    always_comb begin
        req_ready_s = 2'b00;
        if ((state_r == ST_IDLE) && gnt_valid_s && !reset) begin
            req_ready_s = onehot_idx(gnt_idx_s);
        end else begin
            req_ready_s = 2'b00;
        end
    end

    assign accept_s   = |(req_valid & req_ready_s);
    assign key_miss_s = !key_valid_r || (req_key[gnt_idx_s] != loaded_key_r);

`ifdef AES_SCHED_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_r;

    // Count cycles spent in a wait state; cleared in every other state so each wait starts at 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt_r <= 16'd0;
        end else if ((state_r == ST_KEY_WAIT) || (state_r == ST_RUN)) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
        end else begin
            wd_cnt_r <= 16'd0;
        end
    end

    assign wd_expire_s = ((state_r == ST_KEY_WAIT) || (state_r == ST_RUN)) && (wd_cnt_r == WD_LAST);
`else
    logic [31:0] wd_unused_s;
    assign wd_unused_s = 32'(TIMEOUT_CYCLES);
    assign wd_expire_s = 1'b0;
`endif

    // Job sequencer: owns every core strobe, the trigger and the response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            owner_r         <= 1'b0;
            key_valid_r     <= 1'b0;
            loaded_key_r    <= 128'd0;
            core_key_r      <= 128'd0;
            core_data_r     <= 128'd0;
            core_key_load_r <= 1'b0;
            core_start_r    <= 1'b0;
            trig_r          <= 1'b0;
            busy_r          <= 1'b0;
            rsp_valid_r     <= 2'b00;
            rsp_data_r      <= 128'd0;
            rsp_err_r       <= 1'b0;
        end else begin
            core_key_load_r <= 1'b0;
            core_start_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r     <= gnt_idx_s;
                        core_key_r  <= req_key[gnt_idx_s];
                        core_data_r <= req_data[gnt_idx_s];
                        busy_r      <= 1'b1;
                        if (key_miss_s) begin
                            state_r         <= ST_KEY_LOAD;
                            core_key_load_r <= 1'b1;
                        end else begin
                            state_r      <= ST_START;
                            core_start_r <= 1'b1;
                            trig_r       <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_KEY_LOAD: begin
                    loaded_key_r <= core_key_r;
                    key_valid_r  <= 1'b0;
                    state_r      <= ST_KEY_WAIT;
                end
                ST_KEY_WAIT: begin
                    if (core_key_done) begin
                        key_valid_r  <= 1'b1;
                        state_r      <= ST_START;
                        core_start_r <= 1'b1;
                        trig_r       <= 1'b1;
                    end else if (wd_expire_s) begin
                        key_valid_r <= 1'b0;
                        trig_r      <= 1'b0;
                        rsp_data_r  <= 128'd0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= onehot_idx(owner_r);
                        state_r     <= ST_RESP;
                    end else begin
                        state_r <= ST_KEY_WAIT;
                    end
                end
                ST_START: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (core_done) begin
                        trig_r      <= 1'b0;
                        rsp_data_r  <= core_result;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= onehot_idx(owner_r);
                        state_r     <= ST_RESP;
                    end else if (wd_expire_s) begin
                        key_valid_r <= 1'b0;
                        trig_r      <= 1'b0;
                        rsp_data_r  <= 128'd0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= onehot_idx(owner_r);
                        state_r     <= ST_RESP;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[owner_r]) begin
                        rsp_valid_r <= 2'b00;
                        rsp_err_r   <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    trig_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    rsp_valid_r <= 2'b00;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_s;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_err       = rsp_err_r;
    assign core_key      = core_key_r;
    assign core_data     = core_data_r;
    assign core_key_load = core_key_load_r;
    assign core_start    = core_start_r;
    assign trig_o        = trig_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Self-checking bench for aes_job_scheduler with a behavioural AES core model
// and a response scoreboard.
module tb_aes_job_scheduler;

    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1  = 128'hdeadbeef_00000000_11111111_22222222;
    localparam logic [127:0] P1  = 128'h0badf00d_33333333_44444444_55555555;

    logic               clock = 1'b0;
    logic               reset;
    logic [1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0][127:0]  req_key, req_data;
    logic [127:0]       rsp_data, core_key, core_data, core_result;
    logic               rsp_err, core_key_load, core_key_done, core_start, core_done, trig_o, busy_o;

    typedef struct {
        logic [1:0]   owner_oh;
        logic [127:0] data;
        logic         err;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_load = 0;
    bit hang = 1'b0;

    always #5 clock = ~clock;

    aes_job_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_key(core_key), .core_data(core_data),
        .core_key_load(core_key_load), .core_key_done(core_key_done),
        .core_start(core_start), .core_done(core_done),
        .core_result(core_result),
        .trig_o(trig_o), .busy_o(busy_o)
    );

    // Stand-in cipher: the FIPS-197 vector for the known pair, a keyed mix otherwise.
    function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
        if (k == K0 && p == P0) return CT0;
        return k ^ {p[63:0], p[127:64]} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (core_key_load === 1'b1) n_load <= n_load + 1;

    // Core model: key latency 2, encryption latency 3; uses the key it was last loaded with.
    logic [127:0] m_key, m_pt;
    int k_cnt, r_cnt;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_key <= 128'd0; m_pt <= 128'd0; k_cnt <= 0; r_cnt <= 0;
            core_key_done <= 1'b0; core_done <= 1'b0;
        end else begin
            core_key_done <= 1'b0;
            core_done <= 1'b0;
            if (core_key_load) begin
                m_key <= core_key; k_cnt <= 2;
            end else if (k_cnt > 0) begin
                if (k_cnt == 1) core_key_done <= 1'b1;
                k_cnt <= k_cnt - 1;
            end
            if (core_start) begin
                m_pt <= core_data; r_cnt <= 3;
            end else if (r_cnt > 0) begin
                if (r_cnt == 1 && !hang) core_done <= 1'b1;
                r_cnt <= r_cnt - 1;
            end
        end
    end
    assign core_result = model_enc(m_key, m_pt);

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    // Present a job on requester idx and wait (bounded) for it to be accepted.
    task automatic send(input int idx, input logic [127:0] k, input logic [127:0] p, output bit ok);
        exp_t e;
        int t;
        req_key[idx] = k; req_data[idx] = p; req_valid[idx] = 1'b1;
        e.owner_oh = (idx == 1) ? 2'b10 : 2'b01;
        e.data = model_enc(k, p);
        e.err = 1'b0;
        sb.push_back(e);
        ok = 1'b0;
        t = 0;
        #1;
        while (req_ready[idx] !== 1'b1 && t < 40) begin step(); t++; end
        if (req_ready[idx] === 1'b1) begin ok = 1'b1; step(); end
        req_valid[idx] = 1'b0;
    endtask

    // Follow a job to its response while tracking the trigger window, then consume it.
    task automatic collect(output bit ok, output logic [1:0] v, output logic [127:0] d,
                           output logic e, output int trig_bad, output int starts);
        bit win;
        int t;
        win = 1'b0; t = 0; trig_bad = 0; starts = 0; ok = 1'b0;
        while (t < 100) begin
            if (core_start === 1'b1) begin win = 1'b1; starts++; end
            if (trig_o !== win) trig_bad++;
            if (core_done === 1'b1 && win) win = 1'b0;
            if (rsp_valid !== 2'b00) begin ok = 1'b1; break; end
            step(); t++;
        end
        v = rsp_valid; d = rsp_data; e = rsp_err;
        if (ok) begin rsp_ready = v; step(); rsp_ready = 2'b00; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 2'b01;
        step(); step();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, core_key_load, core_start, trig_o, busy_o} !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_ctrl got %b exp 0", {req_ready, rsp_valid, rsp_err, core_key_load, core_start, trig_o, busy_o});
        end
        n_checks++;
        if ({rsp_data, core_key, core_data} !== 384'd0) begin
            n_errors++;
            $display("FAIL reset_data got %h %h %h exp 0", rsp_data, core_key, core_data);
        end
        req_valid = 2'b00;
        reset = 1'b0;
        step();
        n_checks++;
        if (busy_o !== 1'b0) begin n_errors++; $display("FAIL idle_busy got %b exp 0", busy_o); end
    endtask

    task automatic test_single();
        bit ok; logic [1:0] v; logic [127:0] d; logic e; int tb_bad, st, l0;
        exp_t x;
        l0 = n_load;
        send(0, K0, P0, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL single_accept got timeout exp accept"); end
        collect(ok, v, d, e, tb_bad, st);
        x = sb.pop_front();
        n_checks++;
        if (!ok || v !== x.owner_oh) begin n_errors++; $display("FAIL single_owner got %b exp %b", v, x.owner_oh); end
        n_checks++;
        if (d !== x.data) begin n_errors++; $display("FAIL single_data got %h exp %h", d, x.data); end
        n_checks++;
        if (e !== 1'b0) begin n_errors++; $display("FAIL single_err got %b exp 0", e); end
        n_checks++;
        if (n_load - l0 !== 1) begin n_errors++; $display("FAIL single_loads got %0d exp 1", n_load - l0); end
        n_checks++;
        if (tb_bad !== 0 || st !== 1) begin n_errors++; $display("FAIL single_trig got bad=%0d starts=%0d exp 0/1", tb_bad, st); end
        n_checks++;
        if (busy_o !== 1'b0 || rsp_valid !== 2'b00) begin n_errors++; $display("FAIL single_done got busy=%b v=%b exp 0/00", busy_o, rsp_valid); end
    endtask

    task automatic test_key_reuse();
        bit ok; logic [1:0] v; logic [127:0] d; logic e; int tb_bad, st, l0;
        exp_t x;
        l0 = n_load;
        send(0, K0, P1, ok);
        n_checks++;
        if (!ok || core_start !== 1'b1 || core_key_load !== 1'b0) begin
            n_errors++; $display("FAIL reuse_latency got start=%b load=%b exp 1/0", core_start, core_key_load);
        end
        collect(ok, v, d, e, tb_bad, st);
        x = sb.pop_front();
        n_checks++;
        if (!ok || v !== x.owner_oh || d !== x.data) begin n_errors++; $display("FAIL reuse_data got %b %h exp %b %h", v, d, x.owner_oh, x.data); end
        n_checks++;
        if (n_load - l0 !== 0 || tb_bad !== 0) begin n_errors++; $display("FAIL reuse_loads got %0d trigbad=%0d exp 0/0", n_load - l0, tb_bad); end
        l0 = n_load;
        send(0, K1, P1, ok);
        n_checks++;
        if (!ok || core_key_load !== 1'b1) begin n_errors++; $display("FAIL newkey_load got %b exp 1", core_key_load); end
        collect(ok, v, d, e, tb_bad, st);
        x = sb.pop_front();
        n_checks++;
        if (!ok || d !== x.data) begin n_errors++; $display("FAIL newkey_data got %h exp %h", d, x.data); end
        n_checks++;
        if (n_load - l0 !== 1) begin n_errors++; $display("FAIL newkey_loads got %0d exp 1", n_load - l0); end
    endtask

    task automatic test_contention();
        logic [127:0] ks[2][3];
        logic [127:0] ps[2][3];
        int jp[2];
        int nacc, nrsp, t, acc, l0;
        exp_t x, e;
        do_reset();
        l0 = n_load;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 3; j++) begin
                ks[r][j] = {96'h1234_5678_9abc_def0_1111_2222, 32'(r * 16 + j)};
                ps[r][j] = {32'(r * 256 + j * 7), 96'hcafe_0000_1357_2468_face_b00c};
            end
        end
        for (int j = 0; j < 6; j++) begin
            e.owner_oh = (j % 2 == 1) ? 2'b10 : 2'b01;
            e.data = model_enc(ks[j % 2][j / 2], ps[j % 2][j / 2]);
            e.err = 1'b0;
            sb.push_back(e);
        end
        jp[0] = 0; jp[1] = 0;
        req_key[0] = ks[0][0]; req_data[0] = ps[0][0];
        req_key[1] = ks[1][0]; req_data[1] = ps[1][0];
        req_valid = 2'b11; rsp_ready = 2'b11;
        nacc = 0; nrsp = 0; t = 0;
        #1;
        while ((nacc < 6 || nrsp < 6) && t < 600) begin
            if (rsp_valid !== 2'b00 && sb.size() > 0) begin
                x = sb.pop_front();
                n_checks++;
                if (rsp_valid !== x.owner_oh) begin n_errors++; $display("FAIL cont_owner%0d got %b exp %b", nrsp, rsp_valid, x.owner_oh); end
                n_checks++;
                if (rsp_data !== x.data) begin n_errors++; $display("FAIL cont_data%0d got %h exp %h", nrsp, rsp_data, x.data); end
                nrsp++;
            end
            acc = -1;
            if (req_valid[0] && req_ready[0] === 1'b1) acc = 0;
            else if (req_valid[1] && req_ready[1] === 1'b1) acc = 1;
            if (acc >= 0) begin
                n_checks++;
                if (acc !== nacc % 2) begin n_errors++; $display("FAIL cont_grant%0d got %0d exp %0d", nacc, acc, nacc % 2); end
                nacc++;
            end
            step(); t++;
            if (acc >= 0) begin
                jp[acc]++;
                if (jp[acc] < 3) begin
                    req_key[acc] = ks[acc][jp[acc]]; req_data[acc] = ps[acc][jp[acc]];
                end else begin
                    req_valid[acc] = 1'b0;
                end
                #1;
            end
        end
        req_valid = 2'b00; rsp_ready = 2'b00;
        n_checks++;
        if (nacc !== 6 || nrsp !== 6) begin n_errors++; $display("FAIL cont_count got acc=%0d rsp=%0d exp 6/6", nacc, nrsp); end
        n_checks++;
        if (n_load - l0 !== 6) begin n_errors++; $display("FAIL cont_loads got %0d exp 6", n_load - l0); end
    endtask

    task automatic test_backpressure();
        bit ok; int t, bad;
        exp_t x;
        send(1, K1, P0, ok);
        t = 0;
        while (rsp_valid === 2'b00 && t < 50) begin step(); t++; end
        x = sb.pop_front();
        n_checks++;
        if (!ok || rsp_valid !== x.owner_oh || rsp_data !== x.data) begin
            n_errors++; $display("FAIL bp_first got %b %h exp %b %h", rsp_valid, rsp_data, x.owner_oh, x.data);
        end
        req_key[0] = K0; req_data[0] = P0; req_valid[0] = 1'b1;
        rsp_ready = 2'b01;
        #1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 2'b10 || rsp_data !== x.data || req_ready !== 2'b00 || busy_o !== 1'b1) bad++;
            step();
        end
        n_checks++;
        if (bad !== 0) begin n_errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
        n_checks++;
        if (rsp_valid !== 2'b00 || busy_o !== 1'b0) begin n_errors++; $display("FAIL bp_release got v=%b busy=%b exp 00/0", rsp_valid, busy_o); end
    endtask

    task automatic test_reset_in_run();
        bit ok; logic [1:0] v; logic [127:0] d; logic e; int tb_bad, st, l0, t;
        exp_t x;
        send(0, K1 ^ K0, P1, ok);
        t = 0;
        while (trig_o !== 1'b1 && t < 30) begin step(); t++; end
        n_checks++;
        if (!ok || trig_o !== 1'b1) begin n_errors++; $display("FAIL rr_trig got %b exp 1", trig_o); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, core_key_load, core_start, trig_o, busy_o} !== 9'd0 ||
            {rsp_data, core_key, core_data} !== 384'd0) begin
            n_errors++; $display("FAIL rr_outputs got %b exp 0", {req_ready, rsp_valid, rsp_err, core_key_load, core_start, trig_o, busy_o});
        end
        sb.delete();
        step();
        reset = 1'b0;
        repeat (5) step();
        n_checks++;
        if (rsp_valid !== 2'b00 || busy_o !== 1'b0) begin n_errors++; $display("FAIL rr_silent got v=%b busy=%b exp 00/0", rsp_valid, busy_o); end
        l0 = n_load;
        send(0, K1 ^ K0, P0, ok);
        n_checks++;
        if (!ok || core_key_load !== 1'b1) begin n_errors++; $display("FAIL rr_reload got %b exp 1", core_key_load); end
        collect(ok, v, d, e, tb_bad, st);
        x = sb.pop_front();
        n_checks++;
        if (!ok || v !== x.owner_oh || d !== x.data || n_load - l0 !== 1) begin
            n_errors++; $display("FAIL rr_job got %b %h loads=%0d exp %b %h 1", v, d, n_load - l0, x.owner_oh, x.data);
        end
    endtask

`ifdef AES_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok; int t, s, r;
        exp_t x;
        hang = 1'b1;
        send(1, K0, P1, ok);
        sb[sb.size() - 1].data = 128'd0;
        sb[sb.size() - 1].err = 1'b1;
        t = 0;
        while (core_start !== 1'b1 && t < 20) begin step(); t++; end
        s = cyc;
        t = 0;
        while (rsp_valid === 2'b00 && t < 60) begin step(); t++; end
        r = cyc;
        x = sb.pop_front();
        n_checks++;
        if (!ok || r - s !== 17) begin n_errors++; $display("FAIL wd_latency got %0d exp 17", r - s); end
        n_checks++;
        if (rsp_valid !== x.owner_oh || rsp_err !== x.err || rsp_data !== x.data || trig_o !== 1'b0) begin
            n_errors++; $display("FAIL wd_resp got v=%b err=%b d=%h trig=%b exp %b %b %h 0", rsp_valid, rsp_err, rsp_data, trig_o, x.owner_oh, x.err, x.data);
        end
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
        hang = 1'b0;
    endtask
`endif

    initial begin
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_key = '0; req_data = '0;
        reset = 1'b1;
        test_reset();
        test_single();
        test_key_reuse();
        test_contention();
        test_backpressure();
        test_reset_in_run();
`ifdef AES_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_job_scheduler.md
# aes_job_scheduler

Sequencer and two-way round-robin arbiter that shares one AES-128 encryption core between two requesters: the AXI4-Lite register front-end and the internal plaintext generator used for side-channel trace campaigns. It owns every core control strobe, skips key expansion when the next job reuses the loaded key, and drives the trace trigger (`trig_o`) that frames exactly the encryption window.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: watchdog limit per wait state. Used only with `AES_SCHED_WATCHDOG_EN`.

Ports:
- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in [1:0]: job request, one bit per requester; index 0 = AXI front-end, 1 = generator.
- `req_ready` out [1:0]: job accepted when `req_valid[i] & req_ready[i]`.
- `req_key` in 2x128: per-requester key.
- `req_data` in 2x128: per-requester plaintext.
- `rsp_valid` out [1:0]: ciphertext available for requester i.
- `rsp_ready` in [1:0]: response consumed.
- `rsp_data` out 128: ciphertext, shared by both requesters.
- `rsp_err` out 1: job aborted by the watchdog, qualified by `rsp_valid`.
- `core_key` out 128, `core_data` out 128: operands to the core, registered.
- `core_key_load` out 1: one-cycle key-expansion strobe.
- `core_key_done` in 1: key expansion complete.
- `core_start` out 1: one-cycle encryption strobe.
- `core_done` in 1: one-cycle ciphertext-valid strobe.
- `core_result` in 128: ciphertext from the core.
- `trig_o` out 1: SCA trigger.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, KEY_LOAD, KEY_WAIT, START, RUN, RESP.
- IDLE: grant = round-robin among the asserted `req_valid` bits. Priority goes to the requester not served last; requester 0 wins after reset. `req_ready[grant]` is driven combinationally high only in IDLE and only for the granted index.
- On accept:
  - latch key, data and owner;
  - flip the RR pointer;
  - go to KEY_LOAD if `!key_valid || req_key != loaded_key`, otherwise go to START.
- KEY_LOAD: `core_key_load`=1 for one cycle. Store `loaded_key` and clear `key_valid`. Go to KEY_WAIT.
- KEY_WAIT: hold until `core_key_done`. Then set `key_valid` and go to START.
- START: `core_start`=1 for one cycle. `trig_o` rises in this cycle. Go to RUN.
- RUN: hold until `core_done`. Then capture `core_result` into `rsp_data`, drop `trig_o`, and go to RESP.
- RESP: `rsp_valid[owner]` is held high with stable data until `rsp_ready[owner]`. Then return to IDLE. `rsp_ready` of the non-owner is ignored.
- The key comparison is a full 128-bit equality. The owner index does not take part in reload decisions.

## Timing
- Reset value of every output is 0. Reset also sets: state IDLE, `key_valid` 0, RR pointer 0, watchdog counter 0.
- Reset mid-job aborts the job silently with no response. The core shares the same `reset`.
- Accept to `core_start`:
  - key hit: 1 cycle;
  - key miss: 3 cycles plus the core's key latency.
- `trig_o` is high from the START cycle up to and including the cycle in which `core_done` is sampled. It is registered and glitch-free.
- `core_done` arriving in the START cycle is ignored; only RUN samples it. A `core_done` or `core_key_done` outside its wait state is ignored.
- Response to next accept: minimum 1 cycle, i.e. IDLE is always visited for at least one cycle.
- Both requesters valid and continuously re-requesting: strictly alternating grants.

## Configuration
- `AES_SCHED_WATCHDOG_EN` defined:
  - a 16-bit counter runs in KEY_WAIT and RUN and clears on state entry;
  - on reaching `TIMEOUT_CYCLES - 1` the FSM goes to RESP with `rsp_err`=1 and `rsp_data`=0;
  - it also clears `key_valid` and drops `trig_o`.
- Undefined: no counter, `rsp_err` tied 0, and the wait states hold indefinitely.

## Structure
- `aes_sched_pkg`:
  - `AES_BLOCK_W`=128 and `AES_KEY_W`=128;
  - state enum `aes_sched_state_t`;
  - requester index type `req_idx_t` (1 bit).
- Sub-module `aes_rr_arbiter`: 2-way round-robin grant from the request vector and last-grant pointer, with a pointer-update input. The rest is a single FSM module.

## Test plan
- Single job, AXI side: req0 with key 000102…0F and plaintext 00112233…EEFF. The model core returns 69C4E0D8…C55A. Required: `core_key_load` once, `rsp_data`=69C4E0D8…C55A on `rsp_valid[0]`, `trig_o` high exactly START..done.
- Key reuse: a second req0 with the same key. Required: no `core_key_load`, and `core_start` one cycle after accept. A third job with a changed key gives exactly one `core_key_load`.
- Contention: both `req_valid` high for 6 jobs with distinct keys. Required: grant order 0,1,0,1,0,1; each response goes only to its owner; 6 key loads.
- Backpressure: hold `rsp_ready` low for 20 cycles. Required: `rsp_valid` and `rsp_data` stable, `req_ready` stays 0, `busy_o`=1.
- Reset in RUN: assert `reset` while `trig_o`=1. Required: all outputs 0 immediately, and the next job reloads the key.
- Watchdog (`AES_SCHED_WATCHDOG_EN`, `TIMEOUT_CYCLES`=16): the core never pulses `core_done`. Required: `rsp_valid` with `rsp_err`=1 and `rsp_data`=0, 16 cycles after entering RUN.
